// File: rtl/otter_decode_stage.sv
// OTTER decode stage: decodes IF_IR/IF_PC into the DE pipeline register and detects load-use hazards.
// Define OTTER_MEXT_EN to enable M-extension (MULDIV) decode; otherwise DE_MULDIV is tied to 0.
module otter_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IF_VALID,
    input  logic [31:0]      IF_IR,
    input  logic [XLEN-1:0]  IF_PC,
    output logic             IF_READY,
    input  logic             EX_READY,
    input  logic             FLUSH,
    output logic             DE_VALID,
    output logic [XLEN-1:0]  DE_PC,
    output logic [31:0]      DE_IR,
    output logic [4:0]       DE_RS1,
    output logic [4:0]       DE_RS2,
    output logic [4:0]       DE_RD,
    output logic [3:0]       DE_ALU_FUN,
    output logic             DE_ALU_SRC_A,
    output logic [1:0]       DE_ALU_SRC_B,
    output logic [1:0]       DE_RF_WR_SEL,
    output logic             DE_RF_WR_EN,
    output logic             DE_MEM_WRITE,
    output logic             DE_MEM_READ2,
    output logic             DE_MULDIV,
    output logic             DE_ILLEGAL,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = IF_IR[6:0];
    assign func3  = IF_IR[14:12];
    assign rs1    = IF_IR[19:15];
    assign rs2    = IF_IR[24:20];
    assign rd     = IF_IR[11:7];

    // Combinational decode of the fetched instruction
    logic [3:0] dec_alu_fun;
    logic       dec_alu_src_a;
    logic [1:0] dec_alu_src_b;
    logic [1:0] dec_rf_wr_sel;
    logic       dec_rf_wr_en;
    logic       dec_mem_write;
    logic       dec_mem_read2;
    logic       dec_muldiv;
    logic       dec_illegal;
    logic       rs1_used;
    logic       rs2_used;

    always_comb begin
        dec_alu_fun   = 4'b0000;
        dec_alu_src_a = 1'b0;
        dec_alu_src_b = 2'd0;
        dec_rf_wr_sel = 2'd3;
        dec_rf_wr_en  = 1'b0;
        dec_mem_write = 1'b0;
        dec_mem_read2 = 1'b0;
        dec_muldiv    = 1'b0;
        dec_illegal   = 1'b0;
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;

        case (opcode)
            OpLui: begin
                dec_alu_fun   = 4'b1001;
                dec_alu_src_a = 1'b1;
                dec_rf_wr_en  = 1'b1;
            end
            OpAuipc: begin
                dec_alu_src_a = 1'b1;
                dec_alu_src_b = 2'd3;
                dec_rf_wr_en  = 1'b1;
            end
            OpJal: begin
                dec_rf_wr_sel = 2'd0;
                dec_rf_wr_en  = 1'b1;
            end
            OpJalr: begin
                dec_alu_src_b = 2'd1;
                dec_rf_wr_sel = 2'd0;
                dec_rf_wr_en  = 1'b1;
                rs1_used      = 1'b1;
            end
            OpBranch: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OpLoad: begin
                dec_alu_src_b = 2'd1;
                dec_rf_wr_sel = 2'd2;
                dec_rf_wr_en  = 1'b1;
                dec_mem_read2 = 1'b1;
                rs1_used      = 1'b1;
            end
            OpStore: begin
                dec_alu_src_b = 2'd2;
                dec_mem_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OpOpImm: begin
                // Only shift-right immediates carry the arithmetic/logical select in IR[30]
                dec_alu_fun   = (func3 == 3'b101) ? {IF_IR[30], func3} : {1'b0, func3};
                dec_alu_src_b = 2'd1;
                dec_rf_wr_en  = 1'b1;
                rs1_used      = 1'b1;
            end
            OpOp: begin
                dec_alu_fun  = {IF_IR[30], func3};
                dec_rf_wr_en = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
`ifdef OTTER_MEXT_EN
                if (IF_IR[31:25] == 7'b0000001) begin
                    dec_muldiv  = 1'b1;
                    dec_alu_fun = {1'b0, func3};
                end
`endif
            end
            OpSystem: begin
                dec_alu_fun   = 4'b1001;
                dec_rf_wr_sel = 2'd1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // DE pipeline register
    logic             de_valid_q, de_valid_d;
    logic [XLEN-1:0]  de_pc_q, de_pc_d;
    logic [31:0]      de_ir_q, de_ir_d;
    logic [4:0]       de_rs1_q, de_rs1_d;
    logic [4:0]       de_rs2_q, de_rs2_d;
    logic [4:0]       de_rd_q, de_rd_d;
    logic [3:0]       de_alu_fun_q, de_alu_fun_d;
    logic             de_alu_src_a_q, de_alu_src_a_d;
    logic [1:0]       de_alu_src_b_q, de_alu_src_b_d;
    logic [1:0]       de_rf_wr_sel_q, de_rf_wr_sel_d;
    logic             de_rf_wr_en_q, de_rf_wr_en_d;
    logic             de_mem_write_q, de_mem_write_d;
    logic             de_mem_read2_q, de_mem_read2_d;
    logic             de_muldiv_q, de_muldiv_d;
    logic             de_illegal_q, de_illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_en;
    logic hazard;

    assign load_en = !de_valid_q || EX_READY;
    assign hazard  = IF_VALID && de_valid_q && de_mem_read2_q && (de_rd_q != 5'd0) &&
                     ((rs1_used && (rs1 == de_rd_q)) || (rs2_used && (rs2 == de_rd_q)));
    assign IF_READY = FLUSH || (load_en && !hazard);

    always_comb begin
        de_valid_d     = de_valid_q;
        de_pc_d        = de_pc_q;
        de_ir_d        = de_ir_q;
        de_rs1_d       = de_rs1_q;
        de_rs2_d       = de_rs2_q;
        de_rd_d        = de_rd_q;
        de_alu_fun_d   = de_alu_fun_q;
        de_alu_src_a_d = de_alu_src_a_q;
        de_alu_src_b_d = de_alu_src_b_q;
        de_rf_wr_sel_d = de_rf_wr_sel_q;
        de_rf_wr_en_d  = de_rf_wr_en_q;
        de_mem_write_d = de_mem_write_q;
        de_mem_read2_d = de_mem_read2_q;
        de_muldiv_d    = de_muldiv_q;
        de_illegal_d   = de_illegal_q;
        stall_cnt_d    = stall_cnt_q;

        if (FLUSH || (load_en && hazard)) begin
            // Empty slot: side-effecting controls must read as 0
            de_valid_d     = 1'b0;
            de_rf_wr_en_d  = 1'b0;
            de_mem_write_d = 1'b0;
            de_mem_read2_d = 1'b0;
            de_muldiv_d    = 1'b0;
            de_illegal_d   = 1'b0;
            if (!FLUSH && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (load_en) begin
            de_valid_d     = IF_VALID;
            de_pc_d        = IF_PC;
            de_ir_d        = IF_IR;
            de_rs1_d       = rs1;
            de_rs2_d       = rs2;
            de_rd_d        = rd;
            de_alu_fun_d   = dec_alu_fun;
            de_alu_src_a_d = dec_alu_src_a;
            de_alu_src_b_d = dec_alu_src_b;
            de_rf_wr_sel_d = dec_rf_wr_sel;
            de_rf_wr_en_d  = IF_VALID && dec_rf_wr_en;
            de_mem_write_d = IF_VALID && dec_mem_write;
            de_mem_read2_d = IF_VALID && dec_mem_read2;
            de_muldiv_d    = IF_VALID && dec_muldiv;
            de_illegal_d   = IF_VALID && dec_illegal;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            de_valid_q     <= 1'b0;
            de_pc_q        <= '0;
            de_ir_q        <= '0;
            de_rs1_q       <= '0;
            de_rs2_q       <= '0;
            de_rd_q        <= '0;
            de_alu_fun_q   <= '0;
            de_alu_src_a_q <= 1'b0;
            de_alu_src_b_q <= '0;
            de_rf_wr_sel_q <= '0;
            de_rf_wr_en_q  <= 1'b0;
            de_mem_write_q <= 1'b0;
            de_mem_read2_q <= 1'b0;
            de_muldiv_q    <= 1'b0;
            de_illegal_q   <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            de_valid_q     <= de_valid_d;
            de_pc_q        <= de_pc_d;
            de_ir_q        <= de_ir_d;
            de_rs1_q       <= de_rs1_d;
            de_rs2_q       <= de_rs2_d;
            de_rd_q        <= de_rd_d;
            de_alu_fun_q   <= de_alu_fun_d;
            de_alu_src_a_q <= de_alu_src_a_d;
            de_alu_src_b_q <= de_alu_src_b_d;
            de_rf_wr_sel_q <= de_rf_wr_sel_d;
            de_rf_wr_en_q  <= de_rf_wr_en_d;
            de_mem_write_q <= de_mem_write_d;
            de_mem_read2_q <= de_mem_read2_d;
            de_muldiv_q    <= de_muldiv_d;
            de_illegal_q   <= de_illegal_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign DE_VALID     = de_valid_q;
    assign DE_PC        = de_pc_q;
    assign DE_IR        = de_ir_q;
    assign DE_RS1       = de_rs1_q;
    assign DE_RS2       = de_rs2_q;
    assign DE_RD        = de_rd_q;
    assign DE_ALU_FUN   = de_alu_fun_q;
    assign DE_ALU_SRC_A = de_alu_src_a_q;
    assign DE_ALU_SRC_B = de_alu_src_b_q;
    assign DE_RF_WR_SEL = de_rf_wr_sel_q;
    assign DE_RF_WR_EN  = de_rf_wr_en_q;
    assign DE_MEM_WRITE = de_mem_write_q;
    assign DE_MEM_READ2 = de_mem_read2_q;
    assign DE_MULDIV    = de_muldiv_q;
    assign DE_ILLEGAL   = de_illegal_q;
    assign STALL_CNT    = stall_cnt_q;

endmodule
